// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port
//   CPU-facing port of a TMS9918-style video display processor. Answers Z80
//   IO strobes on the data port (port_sel=0) and the control/status port
//   (port_sel=1), decodes the two-byte control protocol, owns the
//   auto-incrementing VRAM address, the read-ahead buffer, registers R0..R7
//   and the status byte, and issues single VRAM accesses toward the video
//   block.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   io_wr, io_rd            one-cycle CPU IO strobes (io_wr wins if both)
//   port_sel                0 = data port, 1 = control/status port
//   cpu_din / cpu_dout      CPU write data / combinational read data
//   vram_req/we/addr/wdata  pending VRAM access, held until vram_ack
//   vram_rdata, vram_ack    read data and one-cycle completion
//   regs                    R0..R7 packed, R0 in [7:0]
//   frame_irq, coinc        set pulses for F and C
//   fifth_spr, fifth_num    set pulse for 5S and the sprite number
//   int_n                   registered ~(F & R1[5])
//   busy                    a VRAM access is pending
//   overrun                 sticky "access dropped while busy" flag
//   fsm_state               debug view of the VRAM access state (0=IDLE, 1=REQ)
//
// Handshake: an access is issued on the clock edge that samples the CPU
// strobe; vram_req rises after that edge and stays high, with we/addr/wdata
// stable, until the edge that samples vram_ack high. vram_req is low in the
// cycle after ack, and a new access may be issued in that cycle.
//
// Configuration
//   VDP_OVERRUN_FLAG_EN  defined: overrun is a sticky flag cleared only by
//                        reset. Undefined: overrun is tied low; accesses
//                        arriving while busy are still dropped.

module vdp_cpu_port #(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic                  port_sel,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_ack,
  output logic [8*NUM_REGS-1:0] regs,
  input  logic                  frame_irq,
  input  logic                  coinc,
  input  logic                  fifth_spr,
  input  logic [4:0]            fifth_num,
  output logic                  int_n,
  output logic                  busy,
  output logic                  overrun,
  output logic                  fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } vram_state_e;

  vram_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              flag_q;
  logic [7:0]        latch_q;
  logic [7:0]        reg_q [NUM_REGS];
  logic [7:0]        rd_buf_q;
  logic              f_q, c_q, s5_q;
  logic [4:0]        fifth_q;
  logic              int_n_q;
  logic              we_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [7:0]        wdata_q;

  // Strobe decode. A simultaneous read strobe is ignored in favour of the write.
  logic rd_cycle;
  logic ctrl_wr, data_wr, data_rd, stat_rd;
  logic second_byte, reg_wr, addr_set, rd_setup;
  logic want_access, issue;
  logic [ADDR_W-1:0] setup_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic              read_done;

  always_comb begin
    rd_cycle    = io_rd & ~io_wr;
    ctrl_wr     = io_wr & port_sel;
    data_wr     = io_wr & ~port_sel;
    data_rd     = rd_cycle & ~port_sel;
    stat_rd     = rd_cycle & port_sel;
    second_byte = ctrl_wr & flag_q;
    reg_wr      = second_byte & cpu_din[7];
    addr_set    = second_byte & ~cpu_din[7];
    rd_setup    = addr_set & ~cpu_din[6];
    setup_addr  = ADDR_W'({cpu_din[5:0], latch_q});
    // Every access that needs the VRAM port; only one may be outstanding.
    want_access = data_wr | data_rd | rd_setup;
    issue       = want_access & (state_q == IDLE);
    issue_addr  = rd_setup ? setup_addr : addr_q;
    read_done   = (state_q == REQ) & vram_ack & ~we_q;
  end

  // VRAM access FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue)    state_d = REQ;
      REQ:     if (vram_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pending access: captured on the issuing edge, held while requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      vaddr_q <= '0;
      wdata_q <= 8'h00;
    end else if (issue) begin
      we_q    <= data_wr;
      vaddr_q <= issue_addr;
      wdata_q <= cpu_din;
    end
  end

  // VRAM address: loaded by an address setup, bumped on every issued access.
  // A read setup loads and bumps in the same edge. A dropped access leaves
  // the address where it was (a dropped read setup still loads it).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else if (addr_set) begin
      addr_q <= issue ? setup_addr + 1'b1 : setup_addr;
    end else if (issue) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Two-byte control protocol state. Any data or status access resets it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q  <= 1'b0;
      latch_q <= 8'h00;
    end else if (ctrl_wr) begin
      flag_q <= ~flag_q;
      if (!flag_q) latch_q <= cpu_din;
    end else if (data_wr | data_rd | stat_rd) begin
      flag_q <= 1'b0;
    end
  end

  // Control registers; bits 6:3 of the second byte are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= 8'h00;
    end else if (reg_wr) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (cpu_din[2:0] == 3'(i)) reg_q[i] <= latch_q;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[8*i +: 8] = reg_q[i];
  end

  // Read-ahead buffer: written data is mirrored immediately, read data
  // arrives with the acknowledge. The two can never coincide because a
  // write only issues from IDLE and a read completes only in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              rd_buf_q <= 8'h00;
    else if (data_wr && issue) rd_buf_q <= cpu_din;
    else if (read_done)        rd_buf_q <= vram_rdata;
  end

  // Status flags: a status read clears them on the edge ending the strobe,
  // but a set pulse on that same edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q     <= 1'b0;
      c_q     <= 1'b0;
      s5_q    <= 1'b0;
      fifth_q <= 5'h1F;
    end else begin
      f_q  <= (f_q  & ~stat_rd) | frame_irq;
      c_q  <= (c_q  & ~stat_rd) | coinc;
      s5_q <= (s5_q & ~stat_rd) | fifth_spr;
      // Keep the first fifth-sprite number until 5S has been read.
      if (fifth_spr && !s5_q) fifth_q <= fifth_num;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) int_n_q <= 1'b1;
    else          int_n_q <= ~(f_q & reg_q[1][5]);
  end

`ifdef VDP_OVERRUN_FLAG_EN
  logic overrun_q;
  logic drop;
  assign drop = want_access & (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  overrun_q <= 1'b0;
    else if (drop) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign cpu_dout   = port_sel ? {f_q, s5_q, c_q, fifth_q} : rd_buf_q;
  assign vram_req   = (state_q == REQ);
  assign busy       = (state_q == REQ);
  assign vram_we    = we_q;
  assign vram_addr  = vaddr_q;
  assign vram_wdata = wdata_q;
  assign int_n      = int_n_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_wr = 1'b0, io_rd = 1'b0, port_sel = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_ack = 1'b0;
  logic [63:0] regs;
  logic        frame_irq = 1'b0, coinc = 1'b0, fifth_spr = 1'b0;
  logic [4:0]  fifth_num = 5'h00;
  logic        int_n, busy, overrun, fsm_state;

  vdp_cpu_port dut (
    .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd),
    .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
    .regs(regs), .frame_irq(frame_irq), .coinc(coinc), .fifth_spr(fifth_spr),
    .fifth_num(fifth_num), .int_n(int_n), .busy(busy), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // scoreboard queues: {we, addr, wdata(0 for reads)} and CPU read data
  logic [22:0] exp_vram_q[$];
  logic [7:0]  exp_rd_q[$];

  // VRAM contents seen by the DUT, and the reference model's own copy
  logic [7:0] vram_mem [16384];
  logic [7:0] ref_mem  [16384];
  logic       hold_ack = 1'b0;

  // reference model of the CPU-visible state
  logic [13:0] m_addr = 14'h0;
  logic        m_flag = 1'b0;
  logic [7:0]  m_latch = 8'h00;
  logic [7:0]  m_regs [8];
  logic [7:0]  m_rdbuf = 8'h00;
  logic        m_f = 1'b0, m_c = 1'b0, m_s5 = 1'b0;
  logic [4:0]  m_fifth = 5'h1F;
  logic        m_ovr = 1'b0;
  logic        m_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic logic exp_ovr();
`ifdef VDP_OVERRUN_FLAG_EN
    return m_ovr;
`else
    return 1'b0;
`endif
  endfunction

  // VRAM responder / monitor: acks after a random delay and checks each access
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (vram_ack) begin
        vram_ack = 1'b0;
      end else if (vram_req && !hold_ack && $urandom_range(0, 2) == 0) begin
        if (exp_vram_q.size() == 0) begin
          check("vram_unexpected", {41'h0, vram_we, vram_addr, vram_wdata}, 64'h0);
        end else begin
          e = exp_vram_q.pop_front();
          check("vram_access", {41'h0, vram_we, vram_addr, vram_we ? vram_wdata : 8'h00},
                {41'h0, e});
        end
        if (vram_we) vram_mem[vram_addr] = vram_wdata;
        else         vram_rdata = vram_mem[vram_addr];
        vram_ack = 1'b1;
      end
    end
  end

  // CPU read monitor: checks cpu_dout in every read strobe cycle
  initial begin
    forever begin
      @(negedge clk);
      if (io_rd && !io_wr) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", {56'h0, cpu_dout}, 64'h0);
        else                      check("cpu_read", {56'h0, cpu_dout}, {56'h0, exp_rd_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic strobe(input logic wr, input logic rd, input logic sel,
                        input logic [7:0] d, input logic fr);
    @(posedge clk); #1;
    io_wr = wr; io_rd = rd; port_sel = sel; cpu_din = d; frame_irq = fr;
    @(posedge clk); #1;
    io_wr = 1'b0; io_rd = 1'b0; frame_irq = 1'b0;
  endtask

  task automatic m_issue(input logic we, input logic [13:0] a, input logic [7:0] d);
    exp_vram_q.push_back({we, a, we ? d : 8'h00});
    if (we) begin
      ref_mem[a] = d;
      m_rdbuf = d;
    end else begin
      m_rdbuf = ref_mem[a];
    end
    m_busy = 1'b1;
  endtask

  task automatic ctrl_write(input logic [7:0] d, input logic both);
    if (!m_flag) begin
      m_latch = d;
      m_flag = 1'b1;
    end else begin
      m_flag = 1'b0;
      if (d[7]) begin
        m_regs[d[2:0]] = m_latch;
      end else begin
        m_addr = {d[5:0], m_latch};
        if (!d[6]) begin
          if (m_busy) m_ovr = 1'b1;
          else begin m_issue(1'b0, m_addr, 8'h00); m_addr = m_addr + 14'h1; end
        end
      end
    end
    strobe(1'b1, both, 1'b1, d, 1'b0);
  endtask

  task automatic data_write(input logic [7:0] d, input logic both);
    m_flag = 1'b0;
    if (m_busy) m_ovr = 1'b1;
    else begin m_issue(1'b1, m_addr, d); m_addr = m_addr + 14'h1; end
    strobe(1'b1, both, 1'b0, d, 1'b0);
  endtask

  task automatic data_read();
    m_flag = 1'b0;
    exp_rd_q.push_back(m_rdbuf);
    if (m_busy) m_ovr = 1'b1;
    else begin m_issue(1'b0, m_addr, 8'h00); m_addr = m_addr + 14'h1; end
    strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic status_read(input logic fr);
    m_flag = 1'b0;
    exp_rd_q.push_back({m_f, m_s5, m_c, m_fifth});
    m_f = fr; m_c = 1'b0; m_s5 = 1'b0;
    strobe(1'b0, 1'b1, 1'b1, 8'h00, fr);
  endtask

  task automatic pulse(input logic f, input logic c, input logic s, input logic [4:0] n);
    if (s && !m_s5) m_fifth = n;
    m_f = m_f | f; m_c = m_c | c; m_s5 = m_s5 | s;
    @(posedge clk); #1;
    frame_irq = f; coinc = c; fifth_spr = s; fifth_num = n;
    @(posedge clk); #1;
    frame_irq = 1'b0; coinc = 1'b0; fifth_spr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check("wait_idle_timeout", 64'h1, 64'h0);
    m_busy = 1'b0;
  endtask

  task automatic check_state(input logic exp_busy);
    logic [63:0] er;
    logic        e_int;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) er[8*i +: 8] = m_regs[i];
    e_int = ~(m_f & m_regs[1][5]);
    check("regs", regs, er);
    check("int_n", {63'h0, int_n}, {63'h0, e_int});
    check("busy", {63'h0, busy}, {63'h0, exp_busy});
    check("vram_req", {63'h0, vram_req}, {63'h0, exp_busy});
    check("overrun", {63'h0, overrun}, {63'h0, exp_ovr()});
    port_sel = 1'b1; #1;
    check("status", {56'h0, cpu_dout}, {56'h0, m_f, m_s5, m_c, m_fifth});
    port_sel = 1'b0; #1;
    check("rd_buf", {56'h0, cpu_dout}, {56'h0, m_rdbuf});
  endtask

  task automatic settle();
    if (m_busy) wait_idle();
    check_state(1'b0);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 16384; i++) begin
      b = 8'($urandom);
      vram_mem[i] = b;
      ref_mem[i]  = b;
    end
    vram_mem[16'h1000] = 8'h5A; ref_mem[16'h1000] = 8'h5A;
    vram_mem[16'h1001] = 8'h3C; ref_mem[16'h1001] = 8'h3C;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

    #23 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_fsm_state", {63'h0, fsm_state}, 64'h0);
    check_state(1'b0);

    // address setup for write, two data writes
    ctrl_write(8'h34, 1'b0); ctrl_write(8'h40, 1'b0);
    data_write(8'hAA, 1'b0); settle();
    data_write(8'h55, 1'b0); settle();

    // R1 write, frame interrupt, status read clears it
    ctrl_write(8'hE2, 1'b0); ctrl_write(8'h81, 1'b0); settle();
    pulse(1'b1, 1'b0, 1'b0, 5'h00); check_state(1'b0);
    status_read(1'b0); settle();

    // address wrap at the top of VRAM
    ctrl_write(8'hFF, 1'b0); ctrl_write(8'h3F, 1'b0); settle();
    data_write(8'h77, 1'b0); settle();

    // read setup then two data reads
    ctrl_write(8'h00, 1'b0); ctrl_write(8'h10, 1'b0); settle();
    data_read(); settle();
    data_read(); settle();

    // status read resets the first/second byte flag
    ctrl_write(8'h12, 1'b0); status_read(1'b0);
    ctrl_write(8'h00, 1'b0); ctrl_write(8'h40, 1'b0); settle();
    data_write(8'h99, 1'b0); settle();

    // fifth sprite latching and set-wins-over-clear
    pulse(1'b0, 1'b1, 1'b1, 5'h07); pulse(1'b0, 1'b0, 1'b1, 5'h0B); check_state(1'b0);
    pulse(1'b1, 1'b0, 1'b0, 5'h00);
    status_read(1'b1); check_state(1'b0);
    status_read(1'b0); settle();

    // accesses while busy are dropped
    hold_ack = 1'b1;
    data_write(8'hC3, 1'b0);
    data_write(8'h3C, 1'b0);
    data_read();
    check_state(1'b1);
    hold_ack = 1'b0;
    wait_idle();
    data_write(8'hE7, 1'b0); settle();

    // simultaneous write and read strobe: the write is taken
    ctrl_write(8'h21, 1'b1); ctrl_write(8'h87, 1'b1); settle();
    data_write(8'h5D, 1'b1); settle();

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: ctrl_write(8'($urandom), 1'b0);
        1: data_write(8'($urandom), 1'b0);
        2: data_read();
        3: status_read(1'($urandom_range(0, 1)));
        4: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom));
        5: begin
             ctrl_write(8'($urandom), 1'b0);
             ctrl_write(8'h80 | 8'($urandom_range(0, 7)), 1'b0);
           end
        default: begin
             if ($urandom_range(0, 1) == 1) ctrl_write(8'($urandom), 1'b1);
             else                           data_write(8'($urandom), 1'b1);
           end
      endcase
      settle();
    end

    repeat (4) @(negedge clk);
    check("vram_queue_empty", 64'(exp_vram_q.size()), 64'h0);
    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
